// File: rtl/simon_pkg.sv
// Shared types, constants and the LFSR-to-digit mapping for the Simon game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW,
    GAP,
    ENTER,
    WIN,
    LOSE
  } seqstate_t;

  // Feedback taps at bits 7, 5, 4 and 3 of the left-shifting LFSR.
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

  // Largest keycode that is a digit key; everything above is a non-digit key.
  localparam logic [4:0] DIGIT_MAX = 5'd9;

  // Fold the low nibble of the LFSR into a decimal digit (10..15 -> 2..7).
  function automatic logic [3:0] lfsr_digit(input logic [7:0] v);
    if (v[3:0] < 4'd10) begin
      return v[3:0];
    end
    return v[3:0] - 4'd8;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit left-shifting Fibonacci LFSR; a zero seed is replaced by the default seed
// because the all-zero state would lock up.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: load has priority over step, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 8'h00) ? LFSR_SEED_DEFAULT : seed;
    end else if (step) begin
      value_d = {value_q[6:0], ^(value_q & LFSR_TAPS)};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= LFSR_SEED_DEFAULT;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: grows a random digit sequence one level at a time, plays it
// back on the display and checks keypad entries against it.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int MAXLVL    = 8,
  parameter int SHOWTICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic       strobe,
  input  logic [4:0] keycode,
  output logic [3:0] disp,
  output logic       disp_en,
  output logic [3:0] level,
  output logic       lvlmax,
  output logic       win,
  output logic       lose,
  output logic       busy
);

  localparam int IW = (MAXLVL > 1) ? $clog2(MAXLVL) : 1;
  localparam int TW = (SHOWTICKS > 1) ? $clog2(SHOWTICKS) : 1;
  localparam logic [3:0]    LVL_MAX   = 4'(MAXLVL);
  localparam logic [TW-1:0] TICK_LAST = TW'(SHOWTICKS - 1);

  seqstate_t     state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    disp_q, disp_d;
  logic          disp_en_q, disp_en_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          busy_q, busy_d;
  logic [3:0]    seq_q [MAXLVL];
  logic [3:0]    seq_d [MAXLVL];

  logic          lfsr_load;
  logic          lfsr_step;
  logic [7:0]    lfsr_val;
  logic [3:0]    gen_digit;
  logic [3:0]    idx_nxt;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] nxt_ptr;

  simon_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  assign gen_digit = lfsr_digit(lfsr_val);
  assign idx_nxt   = idx_q + 4'd1;
  assign wr_ptr    = IW'(level_q - 4'd1);
  assign rd_ptr    = idx_q[IW-1:0];
  assign nxt_ptr   = idx_nxt[IW-1:0];

  // Game flow: next-state and next-output computation for every registered signal.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    disp_d    = disp_q;
    disp_en_d = disp_en_q;
    win_d     = win_q;
    lose_d    = lose_q;
    seq_d     = seq_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          level_d   = 4'd1;
          idx_d     = 4'd0;
          win_d     = 1'b0;
          lose_d    = 1'b0;
          lfsr_load = 1'b1;
          state_d   = GEN;
        end
      end
      GEN: begin
        // The new digit is written this edge, so at level 1 it must be forwarded
        // straight to the display instead of read back from the array.
        seq_d[wr_ptr] = gen_digit;
        lfsr_step     = 1'b1;
        idx_d         = 4'd0;
        tick_d        = '0;
        disp_en_d     = 1'b1;
        disp_d        = (level_q == 4'd1) ? gen_digit : seq_q[0];
        state_d       = SHOW;
      end
      SHOW: begin
        if (tick_q == TICK_LAST) begin
          disp_en_d = 1'b0;
          state_d   = GAP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      GAP: begin
        if (idx_nxt == level_q) begin
          idx_d   = 4'd0;
          state_d = ENTER;
        end else begin
          idx_d     = idx_nxt;
          tick_d    = '0;
          disp_en_d = 1'b1;
          disp_d    = seq_q[nxt_ptr];
          state_d   = SHOW;
        end
      end
      ENTER: begin
        if (strobe && (keycode <= DIGIT_MAX)) begin
          if (keycode[3:0] == seq_q[rd_ptr]) begin
            if (idx_q == level_q - 4'd1) begin
              if (level_q == LVL_MAX) begin
                win_d   = 1'b1;
                state_d = WIN;
              end else begin
                level_d = level_q + 4'd1;
                state_d = GEN;
              end
            end else begin
              idx_d = idx_nxt;
            end
          end else begin
            lose_d  = 1'b1;
            state_d = LOSE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == GEN) || (state_d == SHOW) || (state_d == GAP);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= 4'd0;
      idx_q     <= 4'd0;
      tick_q    <= '0;
      disp_q    <= 4'd0;
      disp_en_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      disp_q    <= disp_d;
      disp_en_q <= disp_en_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      busy_q    <= busy_d;
    end
  end

  // Sequence storage; only ever read at indices already written this game.
  always_ff @(posedge clk) begin
    seq_q <= seq_d;
  end

  assign disp    = disp_q;
  assign disp_en = disp_en_q;
  assign level   = level_q;
  assign lvlmax  = (level_q == LVL_MAX);
  assign win     = win_q;
  assign lose    = lose_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomized scoreboard bench for simon_sequencer: playback digits are predicted from
// a reference sequence model and checked by an independent display monitor.
module tb_simon_sequencer;

  localparam int MAXLVL    = 4;
  localparam int SHOWTICKS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       strobe = 1'b0;
  logic [4:0] keycode = 5'd0;
  logic [3:0] disp;
  logic       disp_en;
  logic [3:0] level;
  logic       lvlmax;
  logic       win;
  logic       lose;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int seq[MAXLVL];

  always #5 clk = ~clk;

  simon_sequencer #(
    .MAXLVL    (MAXLVL),
    .SHOWTICKS (SHOWTICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed),
    .strobe  (strobe),
    .keycode (keycode),
    .disp    (disp),
    .disp_en (disp_en),
    .level   (level),
    .lvlmax  (lvlmax),
    .win     (win),
    .lose    (lose),
    .busy    (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the game's digit sequence derived from the seed.
  function automatic logic [7:0] lfsr_next(input logic [7:0] b);
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
  endfunction

  function automatic int digit_of(input logic [7:0] b);
    int n;
    n = int'(b[3:0]);
    return (n < 10) ? n : n - 8;
  endfunction

  task automatic build_seq(input logic [7:0] s);
    logic [7:0] l;
    l = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < MAXLVL; i++) begin
      seq[i] = digit_of(l);
      l = lfsr_next(l);
    end
  endtask

  task automatic expect_playback(input int lvl);
    for (int i = 0; i < lvl; i++)
      for (int t = 0; t < SHOWTICKS; t++) exp_q.push_back(seq[i]);
  endtask

  // Display monitor: every cycle with disp_en must match the next predicted digit.
  always @(negedge clk) begin
    int e;
    if (!rst && disp_en) begin
      if (exp_q.size() == 0) begin
        check("disp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("disp", int'(disp), e);
      end
    end
  end

  task automatic press(input int k, input logic with_start);
    strobe  = 1'b1;
    keycode = 5'(k);
    start   = with_start;
    @(negedge clk);
    strobe  = 1'b0;
    start   = 1'b0;
  endtask

  task automatic start_game(input logic [7:0] s, input int exp_first);
    seed  = s;
    start = 1'b1;
    build_seq(s);
    expect_playback(1);
    @(negedge clk);
    start = 1'b0;
    check("gen_busy", int'(busy), 1);
    check("gen_disp_en", int'(disp_en), 0);
    @(negedge clk);
    check("first_disp_en", int'(disp_en), 1);
    if (exp_first >= 0) check("first_digit", int'(disp), exp_first);
  endtask

  // Wait out playback, poking keys that must be ignored while busy.
  task automatic wait_enter(input int lvl);
    int cyc;
    cyc = 0;
    while (busy && cyc < 400) begin
      strobe  = ($urandom_range(0, 3) == 0);
      keycode = 5'($urandom_range(0, 19));
      @(negedge clk);
      strobe = 1'b0;
      cyc++;
    end
    check("enter_timeout", int'(cyc < 400), 1);
    check("playback_done", exp_q.size(), 0);
    check("level", int'(level), lvl);
    check("lvlmax", int'(lvlmax), int'(lvl == MAXLVL));
  endtask

  task automatic play_game(input logic [7:0] s, input int exp_first, input int fail_lvl, input int fail_idx);
    start_game(s, exp_first);
    for (int L = 1; L <= MAXLVL; L++) begin
      wait_enter(L);
      if ($urandom_range(0, 2) == 0) begin
        press(10 + $urandom_range(0, 9), 1'b0);
        check("nondigit_busy", int'(busy), 0);
        check("nondigit_lose", int'(lose), 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_enter_busy", int'(busy), 0);
        check("start_in_enter_level", int'(level), L);
      end
      for (int i = 0; i < L; i++) begin
        if (L == fail_lvl && i == fail_idx) begin
          press((seq[i] + 1 + $urandom_range(0, 8)) % 10, 1'b0);
          check("lose_set", int'(lose), 1);
          check("lose_win", int'(win), 0);
          check("lose_busy", int'(busy), 0);
          for (int k = 0; k < 3; k++) press($urandom_range(0, 19), 1'b0);
          check("lose_held", int'(lose), 1);
          check("lose_level", int'(level), L);
          return;
        end
        if (i == L - 1 && L < MAXLVL) expect_playback(L + 1);
        press(seq[i], ($urandom_range(0, 3) == 0));
        check("entry_lose", int'(lose), 0);
      end
    end
    check("win_set", int'(win), 1);
    check("win_lose", int'(lose), 0);
    check("win_lvlmax", int'(lvlmax), 1);
    for (int k = 0; k < 20; k++) begin
      strobe  = ($urandom_range(0, 1) == 0);
      keycode = 5'($urandom_range(0, 19));
      @(negedge clk);
      strobe = 1'b0;
    end
    check("win_held", int'(win), 1);
    check("win_level", int'(level), MAXLVL);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int fl;
    int fi;
    int cyc;

    // Reset held with start asserted: everything stays idle.
    rst   = 1'b1;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_level", int'(level), 0);
      check("rst_disp_en", int'(disp_en), 0);
      check("rst_win", int'(win), 0);
      check("rst_lose", int'(lose), 0);
      check("rst_busy", int'(busy), 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    play_game(8'h01, 1, 0, 0);
    play_game(8'h00, 1, 2, 1);
    play_game(8'h0C, 4, 0, 0);
    for (int g = 0; g < 6; g++) begin
      s  = 8'($urandom_range(0, 255));
      fl = $urandom_range(0, MAXLVL);
      fi = (fl > 0) ? $urandom_range(0, fl - 1) : 0;
      play_game(s, -1, fl, fi);
    end

    // Reset in the middle of level-3 playback.
    start_game(8'h01, 1);
    wait_enter(1);
    expect_playback(2);
    press(seq[0], 1'b0);
    wait_enter(2);
    press(seq[0], 1'b0);
    expect_playback(3);
    press(seq[1], 1'b0);
    cyc = 0;
    while (!disp_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("show_reached", int'(cyc < 20), 1);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_level", int'(level), 0);
    check("midrst_disp_en", int'(disp_en), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_level", int'(level), 0);
    check("midrst_idle_disp_en", int'(disp_en), 0);

    start_game(8'h05, 5);
    wait_enter(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game-level controller for the Simon memory game.
- Generates a pseudo-random digit sequence and plays it out to the display, one digit per level.
- Checks keypad entries (from the key scanner strobe/keycode) against the stored sequence.
- Produces the win/lose/lvlmax status consumed by the Simon ready/enter control FSM. Sits between the key scanner, the number-entry register and the 7-segment display path.

Parameters:
MAXLVL, 8, number of levels; sequence length at win (1..15)
SHOWTICKS, 2, clock cycles each digit is displayed during playback (>=1)

Ports:
clk  in  1  system clock (scan-rate clock in top level)
rst  in  1  synchronous, active-high reset
start  in  1  begin or restart a game; sampled each clk
seed  in  8  LFSR seed loaded on accepted start
strobe  in  1  one-cycle key-press pulse, synchronous to clk
keycode  in  5  key index; 0-9 are digits, 10-19 are non-digit keys
disp  out  4  digit being played back
disp_en  out  1  disp is valid this cycle
level  out  4  current level, 1..MAXLVL; 0 when idle
lvlmax  out  1  level == MAXLVL
win  out  1  game won, held until restart or reset
lose  out  1  wrong digit entered, held until restart or reset
busy  out  1  playback in progress (GEN, SHOW, GAP); keys ignored

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a posedge: state=IDLE, level=0, idx=0, lfsr=8'h01, disp=0, disp_en=0, win=0, lose=0, busy=0, lvlmax=0. Reset mid-game aborts immediately. The stored sequence need not be cleared.
- LFSR: 8-bit, shifts left. New bit0 = l[7]^l[5]^l[4]^l[3]. On accepted start, a seed of 0 loads 8'h01.
- Digit mapping: d = lfsr[3:0] if lfsr[3:0] < 10, else lfsr[3:0] - 8.
- States: IDLE, GEN, SHOW, GAP, ENTER, WIN, LOSE.
- IDLE/WIN/LOSE: start=1 -> level=1, load seed, clear win/lose, go to GEN. start is ignored in every other state. strobe is ignored in these states.
- GEN (1 cycle): seq[level-1] = d(lfsr), then advance lfsr; idx=0; go to SHOW.
- SHOW: disp=seq[idx], disp_en=1 for exactly SHOWTICKS cycles, then go to GAP.
- GAP (1 cycle): disp_en=0; idx++. If the new idx == level -> idx=0, go to ENTER; else go to SHOW.
- ENTER:
  - strobe with keycode > 9: ignored.
  - strobe with keycode[3:0] == seq[idx]: if idx == level-1, then go to WIN if level == MAXLVL, else level++ and go to GEN. Otherwise idx++.
  - strobe with a mismatch: go to LOSE; lose=1.
- Latencies: accepted start -> first disp_en at start+2 cycles. Final correct key -> next GEN on the following cycle.
- Outputs: all registered. lvlmax is combinational from level. busy=1 in GEN/SHOW/GAP.
- Status outputs: win and lose are never both 1. Both stay in level state until an accepted start.
- Simultaneous start and strobe in ENTER: the strobe is processed and start is ignored.

Decomposition:
- Package simon_pkg:
  - seqstate_t enum (IDLE, GEN, SHOW, GAP, ENTER, WIN, LOSE)
  - LFSR tap constant and default seed 8'h01
  - digit-mapping function
  - DIGIT_MAX = 9
- One sub-module, simon_lfsr: clk, rst, load, seed, step, value[7:0]. It implements the seed-0 substitution.
- Sequence storage: a MAXLVL x 4 register array in the top.

Test Plan:
- Reset: rst=1 for 5 cycles with start=1 -> level=0, disp_en=0, win=0, lose=0 at every edge. Release rst, pulse start with seed=8'h01 -> disp_en=1, disp=1 for 2 cycles, then ENTER.
- Level progression: from the previous case press key 1 -> level=2, playback 1,2. Enter 1,2 -> level=3, playback 1,2,4. Enter 1,2,4 -> level=4, playback 1,2,4,8.
- Lose: at level 2 enter 1, then 3 -> lose=1, win=0, state LOSE. Further strobes change nothing. start -> level=1, lose=0.
- Win and lvlmax (MAXLVL=2): enter 1, then 1,2 -> lvlmax=1 at level 2, then win=1 held for 20 cycles. Keycode 0x10 strobes during ENTER are ignored. Strobes during SHOW are ignored (busy=1).
- Seed 0: start with seed=8'h00 -> first displayed digit 1, identical to seed 8'h01. Seed 8'h0C -> first digit 4 (12-8).
- Reset mid-playback: assert rst during SHOW at level 3 -> next edge state IDLE, disp_en=0, level=0.
